// File: rtl/counter_pkg.sv
// Shared types for the up/down counter family.
package counter_pkg;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_UP   = 2'b01,
        OP_DOWN = 2'b10,
        OP_LOAD = 2'b11
    } op_t;

endpackage : counter_pkg

// File: rtl/counter_next_value.sv
// Next-state and wrap computation for the up/down counter; purely combinational.
module counter_next_value
    import counter_pkg::*;
#(
    parameter int WORD_WIDTH = 8,
    parameter int MAX_VALUE  = 2**WORD_WIDTH-1
) (
    input  logic [WORD_WIDTH-1:0] cur_val,
    input  op_t                   op,
    input  logic                  sat,
    input  logic [WORD_WIDTH-1:0] load_val,
    output logic [WORD_WIDTH-1:0] next_val,
    output logic                  wrap
);

    localparam logic [WORD_WIDTH-1:0] MAX_C  = WORD_WIDTH'(MAX_VALUE);
    localparam logic [WORD_WIDTH-1:0] ZERO_C = '0;
    localparam logic [WORD_WIDTH-1:0] ONE_C  = WORD_WIDTH'(1);

    // Select the next counter value and flag a wrap at either range end
    always_comb begin
        next_val = cur_val;
        wrap     = 1'b0;
        case (op)
            OP_HOLD: begin
                next_val = cur_val;
            end
            OP_UP: begin
                if (cur_val == MAX_C) begin
                    if (sat) begin
                        next_val = cur_val;
                    end else begin
                        next_val = ZERO_C;
                        wrap     = 1'b1;
                    end
                end else begin
                    next_val = cur_val + ONE_C;
                end
            end
            OP_DOWN: begin
                if (cur_val == ZERO_C) begin
                    if (sat) begin
                        next_val = cur_val;
                    end else begin
                        next_val = MAX_C;
                        wrap     = 1'b1;
                    end
                end else begin
                    next_val = cur_val - ONE_C;
                end
            end
            OP_LOAD: begin
                // Loads above the range clamp so d_o can never leave 0..MAX_VALUE
                if (load_val > MAX_C) begin
                    next_val = MAX_C;
                end else begin
                    next_val = load_val;
                end
            end
            default: begin
                next_val = cur_val;
                wrap     = 1'b0;
            end
        endcase
    end

endmodule : counter_next_value

// File: rtl/counter_updown.sv
// Up/down counter with programmable modulus, load, hold and wrap/saturate mode.
// wrap_o is registered so a following stage can use it directly as its enable.
module counter_updown
    import counter_pkg::*;
#(
    parameter int WORD_WIDTH = 8,
    parameter int MAX_VALUE  = 2**WORD_WIDTH-1
) (
    input  logic                  clk_i,
    input  logic                  arst_ni,
    input  logic                  en_i,
    input  op_t                   op_i,
    input  logic                  sat_i,
    input  logic [WORD_WIDTH-1:0] d_i,
    output logic [WORD_WIDTH-1:0] d_o,
    output logic                  will_overflow_o,
    output logic                  will_underflow_o,
    output logic                  wrap_o
);

    localparam logic [WORD_WIDTH-1:0] MAX_C  = WORD_WIDTH'(MAX_VALUE);
    localparam logic [WORD_WIDTH-1:0] ZERO_C = '0;

    logic [WORD_WIDTH-1:0] d_r;
    logic                  wrap_r;
    logic [WORD_WIDTH-1:0] next_s;
    logic                  wrap_s;

    counter_next_value #(
        .WORD_WIDTH (WORD_WIDTH),
        .MAX_VALUE  (MAX_VALUE)
    ) u_next (
        .cur_val  (d_r),
        .op       (op_i),
        .sat      (sat_i),
        .load_val (d_i),
        .next_val (next_s),
        .wrap     (wrap_s)
    );

    // Counter state and wrap pulse; a disabled edge keeps the value and clears the pulse
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            d_r    <= ZERO_C;
            wrap_r <= 1'b0;
        end else if (en_i) begin
            d_r    <= next_s;
            wrap_r <= wrap_s;
        end else begin
            d_r    <= d_r;
            wrap_r <= 1'b0;
        end
    end

    assign d_o              = d_r;
    assign wrap_o           = wrap_r;
    assign will_overflow_o  = (d_r == MAX_C);
    assign will_underflow_o = (d_r == ZERO_C);

endmodule : counter_updown

// File: tb/tb_counter_updown.sv
// Bench for counter_updown: modulus-10 instance against a value model, plus an 8-bit cascade pair.
module tb_counter_updown;
    import counter_pkg::*;

    localparam int M4 = 9;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       en4;
    op_t        op4;
    logic       sat4;
    logic [3:0] d4;
    logic [3:0] q4;
    logic       ovf4, unf4, wrap4;

    logic       en8a;
    op_t        op8;
    logic       sat8;
    logic [7:0] d8;
    logic [7:0] q8a, q8b;
    logic       ovf8a, unf8a, wrap8a, ovf8b, unf8b, wrap8b;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    int m_val;
    bit m_wrap;

    int exp_up[12]       = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int exp_down[5]      = '{2, 1, 0, 9, 8};
    int exp_down_sat[11] = '{8, 7, 6, 5, 4, 3, 2, 1, 0, 0, 0};

    always #5 clk = ~clk;

    counter_updown #(.WORD_WIDTH(4), .MAX_VALUE(M4)) dut4 (
        .clk_i(clk), .arst_ni(arst_n), .en_i(en4), .op_i(op4), .sat_i(sat4), .d_i(d4),
        .d_o(q4), .will_overflow_o(ovf4), .will_underflow_o(unf4), .wrap_o(wrap4)
    );

    counter_updown dut8a (
        .clk_i(clk), .arst_ni(arst_n), .en_i(en8a), .op_i(op8), .sat_i(sat8), .d_i(d8),
        .d_o(q8a), .will_overflow_o(ovf8a), .will_underflow_o(unf8a), .wrap_o(wrap8a)
    );

    counter_updown dut8b (
        .clk_i(clk), .arst_ni(arst_n), .en_i(wrap8a), .op_i(op8), .sat_i(sat8), .d_i(d8),
        .d_o(q8b), .will_overflow_o(ovf8b), .will_underflow_o(unf8b), .wrap_o(wrap8b)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: count range 0..M4 as a plain integer
    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            m_val  <= 0;
            m_wrap <= 1'b0;
        end else if (!en4) begin
            m_wrap <= 1'b0;
        end else begin
            m_wrap <= 1'b0;
            if (op4 == OP_UP) begin
                if (m_val < M4)   m_val <= m_val + 1;
                else if (!sat4) begin m_val <= 0; m_wrap <= 1'b1; end
            end else if (op4 == OP_DOWN) begin
                if (m_val > 0)    m_val <= m_val - 1;
                else if (!sat4) begin m_val <= M4; m_wrap <= 1'b1; end
            end else if (op4 == OP_LOAD) begin
                m_val <= (int'(d4) > M4) ? M4 : int'(d4);
            end
        end
    end

    // Every-cycle comparison of the modulus-10 instance against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_d", int'(q4), m_val);
            check("model_wrap", int'(wrap4), int'(m_wrap));
            check("model_ovf", int'(ovf4), (m_val == M4) ? 1 : 0);
            check("model_unf", int'(unf4), (m_val == 0) ? 1 : 0);
        end
    end

    task automatic step4(input logic en, input op_t op, input logic sat, input logic [3:0] d);
        en4 = en; op4 = op; sat4 = sat; d4 = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        arst_n = 1'b0;
        en4 = 1'b0; op4 = OP_HOLD; sat4 = 1'b0; d4 = 4'd0;
        en8a = 1'b0; op8 = OP_HOLD; sat8 = 1'b0; d8 = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        arst_n = 1'b1;
        chk_en = 1'b1;
        check("rst_d", int'(q4), 0);
        check("rst_wrap", int'(wrap4), 0);
        check("rst_unf", int'(unf4), 1);
        check("rst_ovf", int'(ovf4), 0);
        check("rst_d8", int'(q8a), 0);

        for (int i = 0; i < 12; i++) begin
            step4(1'b1, OP_UP, 1'b0, 4'd0);
            check("up_d", int'(q4), exp_up[i]);
            check("up_wrap", int'(wrap4), (i == 9) ? 1 : 0);
        end

        step4(1'b1, OP_HOLD, 1'b0, 4'd7);
        check("hold_d", int'(q4), 2);

        step4(1'b1, OP_LOAD, 1'b0, 4'd3);
        check("load3_d", int'(q4), 3);
        for (int i = 0; i < 5; i++) begin
            step4(1'b1, OP_DOWN, 1'b0, 4'd0);
            check("down_d", int'(q4), exp_down[i]);
            check("down_wrap", int'(wrap4), (i == 3) ? 1 : 0);
            check("down_unf", int'(unf4), (i == 2) ? 1 : 0);
        end

        step4(1'b1, OP_LOAD, 1'b1, 4'd8);
        check("load8_d", int'(q4), 8);
        for (int i = 0; i < 3; i++) begin
            step4(1'b1, OP_UP, 1'b1, 4'd0);
            check("sat_up_d", int'(q4), 9);
            check("sat_up_wrap", int'(wrap4), 0);
        end
        for (int i = 0; i < 11; i++) begin
            step4(1'b1, OP_DOWN, 1'b1, 4'd0);
            check("sat_down_d", int'(q4), exp_down_sat[i]);
            check("sat_down_wrap", int'(wrap4), 0);
        end
        check("sat_down_unf", int'(unf4), 1);

        step4(1'b1, OP_LOAD, 1'b0, 4'd15);
        check("clamp_d", int'(q4), 9);
        check("clamp_ovf", int'(ovf4), 1);
        for (int i = 0; i < 4; i++) begin
            step4(1'b0, OP_UP, 1'b0, 4'd0);
            check("dis_d", int'(q4), 9);
            check("dis_wrap", int'(wrap4), 0);
        end
        step4(1'b1, OP_UP, 1'b0, 4'd0);
        check("wrap_pre_dis", int'(wrap4), 1);
        step4(1'b0, OP_UP, 1'b0, 4'd0);
        check("dis_clr_wrap", int'(wrap4), 0);
        check("dis_clr_d", int'(q4), 0);

        for (int i = 0; i < 6; i++) step4(1'b1, OP_UP, 1'b0, 4'd0);
        check("pre_rst_d", int'(q4), 6);
        #2;
        arst_n = 1'b0;
        #1;
        check("async_rst_d", int'(q4), 0);
        check("async_rst_wrap", int'(wrap4), 0);
        @(negedge clk);
        #1;
        arst_n = 1'b1;
        step4(1'b1, OP_UP, 1'b0, 4'd0);
        check("post_rst_d", int'(q4), 1);

        en8a = 1'b1; op8 = OP_LOAD; d8 = 8'hFF; sat8 = 1'b0;
        @(posedge clk); #1;
        check("c8_load", int'(q8a), 255);
        check("c8_ovf", int'(ovf8a), 1);
        op8 = OP_UP;
        @(posedge clk); #1;
        check("c8_wrap_d", int'(q8a), 0);
        check("c8_wrap", int'(wrap8a), 1);
        check("c8_hi_before", int'(q8b), 0);
        @(posedge clk); #1;
        check("c8_lo_next", int'(q8a), 1);
        check("c8_wrap_clr", int'(wrap8a), 0);
        check("c8_hi_after", int'(q8b), 1);
        check("c8_hi_wrap", int'(wrap8b), 0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_counter_updown
